// File: rtl/gbc_mbc5_cartridge_target.sv
// MBC5 cartridge model as a Wishbone B4 pipelined target: bank registers,
// ROM/external RAM arrays and a fixed wait-state latency through STALL/ACK.
module gbc_mbc5_cartridge_target #(
  parameter int    RomBanks   = 8,
  parameter int    RamBanks   = 4,
  parameter int    WaitStates = 3,
  parameter string RomInit    = ""
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CYC,
  input  logic        STB,
  input  logic        WE,
  input  logic [15:0] ADDR,
  input  logic [7:0]  DAT_I,
  output logic [7:0]  DAT_O,
  output logic        ACK,
  output logic        STALL
);
  localparam int RomAw = $clog2(RomBanks) + 14;
  localparam int RamAw = $clog2(RamBanks) + 13;
  localparam logic [2:0] WaitLoad = (WaitStates > 0) ? 3'(WaitStates - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, BUSY, ACKS} state_t;

  state_t      state, state_n, state_go;
  logic [2:0]  cnt;
  logic [15:0] addr_q;
  logic        we_q;
  logic [7:0]  dat_q;
  logic [8:0]  rom_bank;
  logic [3:0]  ram_bank;
  logic        ram_en;

  logic [7:0] rom [RomBanks*16384];
  logic [7:0] ram [RamBanks*8192];

  logic             accept, commit, ram_sel;
  logic [RomAw-1:0] rom_idx;
  logic [RamAw-1:0] ram_idx;
  logic [7:0]       rd_data;

  // Blank ROM reads as erased flash.
  initial begin
    for (int i = 0; i < RomBanks*16384; i++) rom[i] = 8'hFF;
  end

  assign STALL    = (state == BUSY);
  assign accept   = CYC & STB & ~STALL;
  assign ACK      = (state == ACKS) & CYC;
  assign commit   = ACK & we_q;
  assign state_go = (WaitStates == 0) ? ACKS : BUSY;

  // Bank wrap falls out of truncating {bank, offset} to the array width.
  assign ram_sel = (addr_q[15:13] == 3'b101);
  assign rom_idx = RomAw'({addr_q[14] ? rom_bank : 9'd0, addr_q[13:0]});
  assign ram_idx = RamAw'({ram_bank, addr_q[12:0]});

  always_comb begin
    rd_data = 8'hFF;
    if (!addr_q[15])           rd_data = rom[rom_idx];
    else if (ram_sel && ram_en) rd_data = ram[ram_idx];
  end

  assign DAT_O = (ACK && !we_q) ? rd_data : 8'h00;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = state_go;
      BUSY:    if (!CYC) state_n = IDLE;
               else if (cnt == 3'd0) state_n = ACKS;
      ACKS:    state_n = accept ? state_go : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      addr_q   <= 16'h0000;
      we_q     <= 1'b0;
      dat_q    <= 8'h00;
      rom_bank <= 9'd1;
      ram_bank <= 4'd0;
      ram_en   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q <= ADDR;
        we_q   <= WE;
        dat_q  <= DAT_I;
        cnt    <= WaitLoad;
      end else if (state == BUSY) begin
        cnt <= cnt - 3'd1;
      end
      if (commit) begin
        unique case (addr_q[15:13])
          3'b000:  ram_en <= (dat_q == 8'h0A);
          3'b001:  if (addr_q[12]) rom_bank[8] <= dat_q[0];
                   else rom_bank[7:0] <= dat_q;
          3'b010:  ram_bank <= dat_q[3:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && commit && ram_sel && ram_en) ram[ram_idx] <= dat_q;
  end

endmodule

// File: tb/tb_gbc_mbc5_cartridge_target.sv
// Directed bench: one target with 3 wait states, one with 0 for back-to-back traffic.
module tb_gbc_mbc5_cartridge_target;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [7:0]  din = 8'h0, dout;
  logic        ack, stall;
  logic        cyc0 = 1'b0, stb0 = 1'b0, we0 = 1'b0;
  logic [15:0] addr0 = 16'h0;
  logic [7:0]  din0 = 8'h0, dout0;
  logic        ack0, stall0;

  int total = 0;
  int bad   = 0;
  int last_stalls;

  always #5 clk = ~clk;

  gbc_mbc5_cartridge_target dut (
    .CLK(clk), .RST(rst), .CYC(cyc), .STB(stb), .WE(we), .ADDR(addr),
    .DAT_I(din), .DAT_O(dout), .ACK(ack), .STALL(stall));

  gbc_mbc5_cartridge_target #(.WaitStates(0)) dut0 (
    .CLK(clk), .RST(rst), .CYC(cyc0), .STB(stb0), .WE(we0), .ADDR(addr0),
    .DAT_I(din0), .DAT_O(dout0), .ACK(ack0), .STALL(stall0));

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // One single-beat transfer on the 3-wait-state target; checks latency and data.
  task automatic xfer(input string tag, input logic w, input logic [15:0] a,
                      input logic [7:0] d, input logic [7:0] exp);
    int lat;
    logic [7:0] q;
    @(negedge clk); cyc = 1'b1; stb = 1'b1; we = w; addr = a; din = d;
    @(negedge clk); stb = 1'b0;
    lat = 1; last_stalls = 0;
    while (!ack && lat < 16) begin
      if (stall) last_stalls++;
      @(negedge clk); lat++;
    end
    q = dout;
    @(negedge clk); cyc = 1'b0; we = 1'b0;
    chk({tag, "_lat"}, 16'(lat), 16'd4);
    chk({tag, "_dat"}, {8'h00, q}, {8'h00, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    #1;
    dut.rom[16'h4000]           = 8'h01;
    dut.rom[5*16384]            = 8'h50;
    dut.rom[5*16384 + 16'h0123] = 8'h5A;
    dut.rom[0]                  = 8'hB0;
    dut0.rom[0]                 = 8'hA0;
    dut0.rom[1]                 = 8'hA1;
    dut0.rom[2]                 = 8'hA2;
    dut0.rom[5*16384]           = 8'h55;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ack",   16'(ack),   16'd0);
    chk("rst_stall", 16'(stall), 16'd0);
    chk("rst_dat",   16'(dout),  16'd0);

    xfer("rd4000", 1'b0, 16'h4000, 8'h00, 8'h01);
    chk("rd4000_stalls", 16'(last_stalls), 16'd3);

    // Abort a bank write while it is waiting.
    @(negedge clk); cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 16'h2000; din = 8'h07;
    @(negedge clk); stb = 1'b0;
    chk("abort_busy", 16'(stall), 16'd1);
    cyc = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("abort_stall", 16'(stall), 16'd0);
    chk("abort_ack",   16'(ack),   16'd0);
    repeat (4) begin
      @(negedge clk);
      chk("abort_noack", 16'(ack), 16'd0);
    end
    xfer("abort_rd", 1'b0, 16'h4000, 8'h00, 8'h01);

    xfer("wr_bank5", 1'b1, 16'h2000, 8'h05, 8'h00);
    xfer("rd_b5",    1'b0, 16'h4123, 8'h00, 8'h5A);
    xfer("wr_bankd", 1'b1, 16'h2000, 8'h0D, 8'h00);
    xfer("rd_wrap",  1'b0, 16'h4000, 8'h00, 8'h50);
    xfer("wr_bank0", 1'b1, 16'h2000, 8'h00, 8'h00);
    xfer("rd_b0hi",  1'b0, 16'h4000, 8'h00, 8'hB0);
    xfer("rd_b0lo",  1'b0, 16'h0000, 8'h00, 8'hB0);

    xfer("ram_off",  1'b0, 16'hA000, 8'h00, 8'hFF);
    xfer("ram_en",   1'b1, 16'h0000, 8'h0A, 8'h00);
    xfer("ram_wr",   1'b1, 16'hA000, 8'h5C, 8'h00);
    xfer("ram_rd",   1'b0, 16'hA000, 8'h00, 8'h5C);
    xfer("ram_dis",  1'b1, 16'h0000, 8'h0B, 8'h00);
    xfer("ram_off2", 1'b0, 16'hA000, 8'h00, 8'hFF);

    xfer("ram_en2",  1'b1, 16'h0000, 8'h0A, 8'h00);
    xfer("rb3",      1'b1, 16'h4000, 8'h03, 8'h00);
    xfer("wr_b3",    1'b1, 16'hA010, 8'h33, 8'h00);
    xfer("rb2",      1'b1, 16'h4000, 8'h02, 8'h00);
    xfer("wr_b2",    1'b1, 16'hA010, 8'h11, 8'h00);
    xfer("rb3b",     1'b1, 16'h4000, 8'h03, 8'h00);
    xfer("rd_b3",    1'b0, 16'hA010, 8'h00, 8'h33);
    xfer("rb2b",     1'b1, 16'h4000, 8'h02, 8'h00);
    xfer("rd_b2",    1'b0, 16'hA010, 8'h00, 8'h11);
    xfer("rb6",      1'b1, 16'h4000, 8'h06, 8'h00);
    xfer("rd_b6",    1'b0, 16'hA010, 8'h00, 8'h11);
    xfer("rd_8000",  1'b0, 16'h8000, 8'h00, 8'hFF);
    xfer("rd_c000",  1'b0, 16'hC000, 8'h00, 8'hFF);

    // Reset in the middle of a pending bank write.
    @(negedge clk); cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 16'h2000; din = 8'h02;
    @(negedge clk); stb = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mrst_stall", 16'(stall), 16'd0);
    repeat (4) begin
      @(negedge clk);
      chk("mrst_noack", 16'(ack), 16'd0);
    end
    cyc = 1'b0; we = 1'b0;
    xfer("mrst_rom", 1'b0, 16'h4000, 8'h00, 8'h01);
    xfer("mrst_ram", 1'b0, 16'hA010, 8'h00, 8'hFF);

    // Zero wait states: STB held for back-to-back reads, then write-then-read.
    @(negedge clk); cyc0 = 1'b1; stb0 = 1'b1; we0 = 1'b0; addr0 = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b_ack",   16'(ack0),   16'd1);
      chk("b2b_stall", 16'(stall0), 16'd0);
      chk("b2b_dat",   16'(dout0),  16'(8'hA0 + i));
      if (i < 2) addr0 = 16'(i + 1);
      else stb0 = 1'b0;
    end
    @(negedge clk);
    chk("b2b_end", 16'(ack0), 16'd0);
    stb0 = 1'b1; we0 = 1'b1; addr0 = 16'h2000; din0 = 8'h05;
    @(negedge clk);
    chk("wr_ack0", 16'(ack0),  16'd1);
    chk("wr_dat0", 16'(dout0), 16'd0);
    we0 = 1'b0; addr0 = 16'h4000;
    @(negedge clk);
    chk("rdw_ack0", 16'(ack0),  16'd1);
    chk("rdw_dat0", 16'(dout0), 16'h55);
    stb0 = 1'b0;
    @(negedge clk); cyc0 = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
